// File: rtl/instruction_fetch_unit.sv
// LITE-16 instruction fetch: owns the PC, fetches over req/ack + rvalid, and holds one instruction for decode.
// Optional memory-timeout fault detection is enabled with `define LITE16_FETCH_TIMEOUT_EN.
module instruction_fetch_unit #(
  parameter logic [15:0] RESET_PC       = 16'h0000,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic        imem_rvalid,
  input  logic [15:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [15:0] instr,
  output logic [3:0]  i4_7,
  output logic [3:0]  i8_11,
  output logic [3:0]  i12_15,
  output logic [15:0] pc_out,
  output logic        fetch_fault
);

`ifdef LITE16_FETCH_TIMEOUT_EN
  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, FAULT} state_t;
`else
  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;
`endif

  state_t      state, state_nxt;
  logic [15:0] pc;
  logic [15:0] fetch_pc;
  logic        drop;
  logic        redir;
  logic        ack_fire;
  logic        rx_fire;
  logic        xfer;
  logic        timeout_hit;

  assign ack_fire = (state == REQ)  && imem_ack;
  assign rx_fire  = (state == WAIT) && imem_rvalid;
  assign xfer     = (state == HOLD) && instr_ready;

`ifdef LITE16_FETCH_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] to_cnt;
  logic             in_rw;
  logic             enter_rw;
  logic             fault_q;

  // Redirects are ignored once the unit has faulted.
  assign redir       = redirect_valid && (state != FAULT);
  assign in_rw       = (state == REQ) || (state == WAIT);
  assign enter_rw    = ((state_nxt == REQ) || (state_nxt == WAIT)) && (state_nxt != state);
  assign timeout_hit = in_rw && !ack_fire && !rx_fire && (to_cnt == CNT_LAST);
  assign fetch_fault = fault_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt  <= '0;
      fault_q <= 1'b0;
    end else begin
      if (enter_rw || ack_fire || rx_fire)
        to_cnt <= '0;
      else if (in_rw)
        to_cnt <= to_cnt + 1'b1;
      if (timeout_hit)
        fault_q <= 1'b1;
    end
  end
`else
  assign redir       = redirect_valid;
  assign timeout_hit = 1'b0;
  assign fetch_fault = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: state_nxt = REQ;
      REQ:  if (ack_fire) state_nxt = WAIT;
      WAIT: if (rx_fire) state_nxt = (drop || redir) ? REQ : HOLD;
      HOLD: if (xfer || redir) state_nxt = REQ;
      default: state_nxt = state;
    endcase
`ifdef LITE16_FETCH_TIMEOUT_EN
    if (timeout_hit)
      state_nxt = FAULT;
`endif
  end

  always_comb begin
    imem_req = (state == REQ);
  end

  assign imem_addr = pc;
  assign i4_7      = instr[7:4];
  assign i8_11     = instr[11:8];
  assign i12_15    = instr[15:12];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      fetch_pc    <= '0;
      instr       <= '0;
      pc_out      <= '0;
      instr_valid <= 1'b0;
      drop        <= 1'b0;
    end else begin
      // A redirect replaces the increment even when the request was acked this cycle.
      if (redir)
        pc <= redirect_pc;
      else if (ack_fire)
        pc <= pc + 16'h0001;

      if (ack_fire)
        fetch_pc <= pc;

      if (rx_fire)
        drop <= 1'b0;
      else if (redir && (ack_fire || (state == WAIT)))
        drop <= 1'b1;

      if (rx_fire && !drop && !redir) begin
        instr       <= imem_rdata;
        pc_out      <= fetch_pc;
        instr_valid <= 1'b1;
      end else if ((state == HOLD) && (instr_ready || redir)) begin
        instr_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed table-driven bench for instruction_fetch_unit with RESET_PC=0010 and TIMEOUT_CYCLES=8.
// Builds with or without LITE16_FETCH_TIMEOUT_EN; the timeout section expects the matching behaviour.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic        imem_rvalid;
  logic [15:0] imem_rdata;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [3:0]  i4_7, i8_11, i12_15;
  logic [15:0] pc_out;
  logic        fetch_fault;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instruction_fetch_unit #(
    .RESET_PC      (16'h0010),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr         (instr),
    .i4_7          (i4_7),
    .i8_11         (i8_11),
    .i12_15        (i12_15),
    .pc_out        (pc_out),
    .fetch_fault   (fetch_fault)
  );

  typedef struct {
    logic        ack;
    logic        rvalid;
    logic [15:0] rdata;
    logic        rdv;
    logic [15:0] rpc;
    logic        rdy;
    logic        e_req;
    logic [15:0] e_addr;
    logic        e_valid;
    logic [15:0] e_instr;
    logic [15:0] e_pc_out;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic ack, input logic rvalid, input logic [15:0] rdata,
                     input logic rdv, input logic [15:0] rpc, input logic rdy,
                     input logic e_req, input logic [15:0] e_addr, input logic e_valid,
                     input logic [15:0] e_instr, input logic [15:0] e_pc_out);
    vec_t v;
    v.ack = ack; v.rvalid = rvalid; v.rdata = rdata; v.rdv = rdv; v.rpc = rpc; v.rdy = rdy;
    v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid;
    v.e_instr = e_instr; v.e_pc_out = e_pc_out;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ack, input logic rvalid, input logic [15:0] rdata,
                       input logic rdv, input logic [15:0] rpc, input logic rdy);
    imem_ack = ack; imem_rvalid = rvalid; imem_rdata = rdata;
    redirect_valid = rdv; redirect_pc = rpc; instr_ready = rdy;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);

    //  ack rv  rdata     rdv rpc       rdy   req addr      vld instr     pc_out
    add(0, 0, 16'h0000, 0, 16'h0000, 0,   0, 16'h0010, 0, 16'h0000, 16'h0000); // IDLE
    add(1, 0, 16'h0000, 0, 16'h0000, 0,   1, 16'h0010, 0, 16'h0000, 16'h0000);
    add(0, 1, 16'hA5C3, 0, 16'h0000, 0,   0, 16'h0011, 0, 16'h0000, 16'h0000);
    for (int k = 0; k < 10; k++)
      add(0, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0011, 1, 16'hA5C3, 16'h0010);
    add(0, 0, 16'h0000, 0, 16'h0000, 1,   0, 16'h0011, 1, 16'hA5C3, 16'h0010);
    add(1, 0, 16'h0000, 0, 16'h0000, 0,   1, 16'h0011, 0, 16'hA5C3, 16'h0010);
    add(0, 0, 16'h0000, 1, 16'h0200, 0,   0, 16'h0012, 0, 16'hA5C3, 16'h0010); // redirect in WAIT
    add(0, 1, 16'h1234, 0, 16'h0000, 0,   0, 16'h0200, 0, 16'hA5C3, 16'h0010); // dropped
    add(1, 0, 16'h0000, 0, 16'h0000, 0,   1, 16'h0200, 0, 16'hA5C3, 16'h0010);
    add(0, 1, 16'hBEEF, 0, 16'h0000, 0,   0, 16'h0201, 0, 16'hA5C3, 16'h0010);
    add(0, 0, 16'h0000, 0, 16'h0000, 1,   0, 16'h0201, 1, 16'hBEEF, 16'h0200);
    add(0, 0, 16'h0000, 1, 16'hFFFF, 0,   1, 16'h0201, 0, 16'hBEEF, 16'h0200); // redirect in REQ
    add(1, 0, 16'h0000, 0, 16'h0000, 0,   1, 16'hFFFF, 0, 16'hBEEF, 16'h0200);
    add(0, 1, 16'h7E81, 0, 16'h0000, 0,   0, 16'h0000, 0, 16'hBEEF, 16'h0200); // PC wrap
    add(0, 0, 16'h0000, 0, 16'h0000, 1,   0, 16'h0000, 1, 16'h7E81, 16'hFFFF);
    add(0, 0, 16'h0000, 1, 16'h0040, 0,   1, 16'h0000, 0, 16'h7E81, 16'hFFFF);
    add(1, 0, 16'h0000, 1, 16'h0080, 0,   1, 16'h0040, 0, 16'h7E81, 16'hFFFF); // redirect + ack
    add(0, 1, 16'hDEAD, 0, 16'h0000, 0,   0, 16'h0080, 0, 16'h7E81, 16'hFFFF);
    add(1, 0, 16'h0000, 0, 16'h0000, 0,   1, 16'h0080, 0, 16'h7E81, 16'hFFFF);
    add(0, 1, 16'hCAFE, 0, 16'h0000, 0,   0, 16'h0081, 0, 16'h7E81, 16'hFFFF);
    add(0, 0, 16'h0000, 1, 16'h0300, 1,   0, 16'h0081, 1, 16'hCAFE, 16'h0080); // redirect + xfer
    add(1, 0, 16'h0000, 0, 16'h0000, 0,   1, 16'h0300, 0, 16'hCAFE, 16'h0080);
    add(0, 1, 16'h5555, 1, 16'h0400, 0,   0, 16'h0301, 0, 16'hCAFE, 16'h0080); // redirect + rvalid
    add(0, 0, 16'h0000, 0, 16'h0000, 0,   1, 16'h0400, 0, 16'hCAFE, 16'h0080);
    add(0, 1, 16'h9999, 0, 16'h0000, 0,   1, 16'h0400, 0, 16'hCAFE, 16'h0080); // stray rvalid
    add(1, 0, 16'h0000, 0, 16'h0000, 0,   1, 16'h0400, 0, 16'hCAFE, 16'h0080);
    add(0, 1, 16'h1111, 0, 16'h0000, 0,   0, 16'h0401, 0, 16'hCAFE, 16'h0080);
    add(0, 0, 16'h0000, 0, 16'h0000, 1,   0, 16'h0401, 1, 16'h1111, 16'h0400);

    @(negedge clk);
    @(negedge clk);
    chk("rst_req",   32'(imem_req),    32'h0);
    chk("rst_valid", 32'(instr_valid), 32'h0);
    chk("rst_instr", 32'(instr),       32'h0);
    chk("rst_pcout", 32'(pc_out),      32'h0);
    chk("rst_fault", 32'(fetch_fault), 32'h0);
    chk("rst_addr",  32'(imem_addr),   32'h0010);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      chk($sformatf("c%0d_req", i),   32'(imem_req),    32'(tbl[i].e_req));
      chk($sformatf("c%0d_addr", i),  32'(imem_addr),   32'(tbl[i].e_addr));
      chk($sformatf("c%0d_valid", i), 32'(instr_valid), 32'(tbl[i].e_valid));
      chk($sformatf("c%0d_instr", i), 32'(instr),       32'(tbl[i].e_instr));
      chk($sformatf("c%0d_pcout", i), 32'(pc_out),      32'(tbl[i].e_pc_out));
      chk($sformatf("c%0d_fault", i), 32'(fetch_fault), 32'h0);
      if (tbl[i].e_valid) begin
        chk($sformatf("c%0d_i4_7", i),   32'(i4_7),   32'(tbl[i].e_instr[7:4]));
        chk($sformatf("c%0d_i8_11", i),  32'(i8_11),  32'(tbl[i].e_instr[11:8]));
        chk($sformatf("c%0d_i12_15", i), 32'(i12_15), 32'(tbl[i].e_instr[15:12]));
      end
      drive(tbl[i].ack, tbl[i].rvalid, tbl[i].rdata, tbl[i].rdv, tbl[i].rpc, tbl[i].rdy);
      @(negedge clk);
    end

    // Memory stops acknowledging: first REQ cycle at 0401.
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
`ifdef LITE16_FETCH_TIMEOUT_EN
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("to%0d_req", k),   32'(imem_req),    32'h1);
      chk($sformatf("to%0d_fault", k), 32'(fetch_fault), 32'h0);
      @(negedge clk);
    end
    chk("flt_req",   32'(imem_req),    32'h0);
    chk("flt_fault", 32'(fetch_fault), 32'h1);
    chk("flt_valid", 32'(instr_valid), 32'h0);
    drive(1'b1, 1'b0, 16'h0000, 1'b1, 16'h0500, 1'b0);
    @(negedge clk);
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("flt%0d_addr", k),  32'(imem_addr),   32'h0401);
      chk($sformatf("flt%0d_req", k),   32'(imem_req),    32'h0);
      chk($sformatf("flt%0d_fault", k), 32'(fetch_fault), 32'h1);
      @(negedge clk);
    end
`else
    for (int k = 0; k < 20; k++) begin
      chk($sformatf("nto%0d_req", k),   32'(imem_req),    32'h1);
      chk($sformatf("nto%0d_addr", k),  32'(imem_addr),   32'h0401);
      chk($sformatf("nto%0d_fault", k), 32'(fetch_fault), 32'h0);
      @(negedge clk);
    end
`endif

    rst_n = 1'b0;
    #1;
    chk("rst2_fault", 32'(fetch_fault), 32'h0);
    chk("rst2_req",   32'(imem_req),    32'h0);
    chk("rst2_addr",  32'(imem_addr),   32'h0010);
    chk("rst2_valid", 32'(instr_valid), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst2_idle_req", 32'(imem_req), 32'h0);
    @(negedge clk);
    chk("rst2_req1",  32'(imem_req),  32'h1);
    chk("rst2_addr1", 32'(imem_addr), 32'h0010);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Upstream neighbour of the register fetch unit in the LITE-16 pipeline.
- Owns the PC and fetches 16-bit instruction words from instruction memory over a req/ack + rvalid handshake.
- Holds each fetched word in an instruction register and presents its nibble fields (i4_7, i8_11, i12_15) plus a valid/ready handshake to the decode/register-fetch stage.
- Accepts a one-cycle redirect from execute for jumps and flushes any in-flight fetch.

Parameters:
RESET_PC  16'h0000  PC value loaded on reset (word address)
TIMEOUT_CYCLES  255  cycles without memory progress before fault (used only with the optional feature)

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
imem_req  output  1  fetch request, high in REQ state
imem_addr  output  16  word address of request, equals pc
imem_ack  input  1  memory accepted the request this cycle
imem_rvalid  input  1  read data valid (exactly one per acked request, in order)
imem_rdata  input  16  instruction word
redirect_valid  input  1  one-cycle jump redirect
redirect_pc  input  16  jump target
instr_valid  output  1  instruction register holds a valid instruction
instr_ready  input  1  downstream consumes the instruction
instr  output  16  instruction register
i4_7  output  4  instr[7:4]
i8_11  output  4  instr[11:8]
i12_15  output  4  instr[15:12]
pc_out  output  16  address the held instruction was fetched from
fetch_fault  output  1  sticky memory-timeout flag

Behaviour:
- Reset (async, rst_n=0): state=IDLE, pc=RESET_PC, instr=0, pc_out=0, instr_valid=0, drop=0, fetch_fault=0. imem_req is decoded from state, so it is 0 during reset.
- States: IDLE, REQ, WAIT, HOLD (+FAULT with the optional feature).
- IDLE: go to REQ the next cycle unconditionally.
- REQ: imem_req=1, imem_addr=pc.
  - imem_ack: fetch_pc<=pc, pc<=pc+1 (16-bit wrap, FFFF->0000), go to WAIT.
  - imem_addr is stable while imem_req=1 without ack, except on redirect.
- WAIT: imem_req=0. At most one request is outstanding.
  - imem_rvalid with drop=1: discard data, drop<=0, go to REQ.
  - imem_rvalid with drop=0: instr<=imem_rdata, pc_out<=fetch_pc, instr_valid<=1, go to HOLD.
- HOLD: instr_valid=1, instr stable.
  - A transfer occurs in a cycle with instr_valid&instr_ready; on transfer, instr_valid<=0 and go to REQ.
  - Minimum spacing is 3 cycles per instruction.
- Redirect (priority over all normal transitions): pc<=redirect_pc and instr_valid<=0 next cycle.
  - REQ without ack: stay REQ; imem_addr shows redirect_pc next cycle.
  - REQ with ack same cycle: the request counts as issued; go to WAIT with drop<=1; pc<=redirect_pc (no +1).
  - WAIT without rvalid: drop<=1, stay in WAIT.
  - WAIT with rvalid same cycle: discard data, go to REQ.
  - HOLD: go to REQ. A transfer in the same cycle is still valid, since the jump instruction itself is accepted.
  - IDLE: pc<=redirect_pc, go to REQ.
- i4_7, i8_11, i12_15 are pure slices of instr.
- instr and pc_out change only on load.
- imem_rvalid outside WAIT is ignored.

Optional Feature:
- Macro: LITE16_FETCH_TIMEOUT_EN.
- Defined:
  - An 8-bit+ counter clears on entering REQ or WAIT and on imem_ack/imem_rvalid.
  - It increments each cycle spent in REQ or WAIT without progress.
  - When it reaches TIMEOUT_CYCLES: fetch_fault<=1 (sticky), state<=FAULT.
  - FAULT: imem_req=0, instr_valid=0, redirects ignored; left only by reset.
- Not defined: no counter and no FAULT state; fetch_fault is tied to 0.

Test Plan:
- Reset with RESET_PC=16'h0010, memory acks immediately and returns rdata=16'hA5C3 one cycle later -> imem_addr=0010; then instr_valid=1, instr=A5C3, i4_7=C, i8_11=5, i12_15=A, pc_out=0010; next request addr=0011.
- instr_ready held low 10 cycles in HOLD -> instr and instr_valid stable, imem_req=0; on ready=1, one transfer and next fetch of pc+1.
- Redirect to 16'h0200 in WAIT, then rvalid with 16'h1234 -> 1234 never presented; next imem_addr=0200; its data is presented with pc_out=0200.
- pc=16'hFFFF fetched and consumed -> next imem_addr=0000.
- Redirect coincident with imem_ack in REQ at pc=0040, target 0080 -> first rvalid dropped, next request addr=0080 (not 0081).
- With LITE16_FETCH_TIMEOUT_EN and TIMEOUT_CYCLES=8, imem_ack never asserted -> fetch_fault=1 after 8 REQ cycles, imem_req=0 thereafter; rst_n pulse clears it. Without the macro -> fetch_fault stays 0 and imem_req stays high.
